// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_HALTED,
        S_ERROR
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without a memory response; flags the last allowed one.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, branch/halt handling, sticky error.
// Optional FETCH_TIMEOUT_EN adds a watchdog that aborts a FETCH with no memory response.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR      = 64'h0,
    parameter int unsigned     TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    input  logic                halt,
    output logic                mem_req,
    output logic [XLEN-1:0]     mem_addr,
    input  logic                mem_ready,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instruction,
    output logic [XLEN-1:0]     pc_out,
    output logic                busy,
    output logic                fetch_err
);

    fetch_state_e        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                pend_q, pend_d;
    logic [XLEN-1:0]     ptgt_q, ptgt_d;
    logic                phalt_q, phalt_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]     pcout_q, pcout_d;
    logic                err_q, err_d;
    logic                timeout;

`ifdef FETCH_TIMEOUT_EN
    logic fetch_entry;

    // Re-issuing after a discarded response counts as a fresh entry into FETCH.
    assign fetch_entry = (state_d == S_FETCH) && !((state_q == S_FETCH) && !mem_ready);

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (fetch_entry),
        .count_en ((state_q == S_FETCH) && !mem_ready),
        .expired  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_ADDR;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
            phalt_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pcout_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
            phalt_q <= phalt_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        phalt_d = phalt_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = BOOT_ADDR;
                    pend_d  = 1'b0;
                    phalt_d = 1'b0;
                end
            end
            S_FETCH: begin
                // Halt/branch are latched here and acted on once the outstanding read returns.
                if (halt) begin
                    phalt_d = 1'b1;
                end else if (branch_taken && !phalt_q) begin
                    if (is_misaligned(branch_target[1:0])) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                        ptgt_d = branch_target;
                    end
                end
                if (state_d == S_FETCH) begin
                    if (mem_ready) begin
                        if (phalt_d) begin
                            state_d = S_HALTED;
                        end else if (pend_d) begin
                            pc_d   = ptgt_d;
                            pend_d = 1'b0;
                        end else begin
                            instr_d = mem_rdata;
                            pcout_d = pc_q;
                            state_d = S_VALID;
                        end
                    end else if (timeout) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_VALID: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (branch_taken) begin
                    if (is_misaligned(branch_target[1:0])) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = branch_target;
                        state_d = S_FETCH;
                    end
                end else if (!stall) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    assign mem_req     = (state_q == S_FETCH);
    assign mem_addr    = mem_req ? pc_q : '0;
    assign instr_valid = (state_q == S_VALID);
    assign instruction = instr_q;
    assign pc_out      = pcout_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Scoreboard bench for instruction_fetch_ctrl: directed scenarios plus randomized episodes.
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        halt = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] pc_out;
    logic        busy;
    logic        fetch_err;

    localparam logic [63:0] BOOT = 64'h0;
    localparam int unsigned TO   = 15;
    localparam logic [31:0] NOP  = 32'h00000013;

    instruction_fetch_ctrl #(
        .BOOT_ADDR      (BOOT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .busy          (busy),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    // Observable behaviour of the controller, as the bench expects it.
    typedef enum {P_UNK, P_IDLE, P_WAIT, P_SHOW, P_HALT, P_ERR} ph_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        int          cyc;
    } pres_t;

    pres_t       pres_q[$];
    pres_t       held;
    ph_t         ph = P_UNK, ph_now = P_UNK;
    logic [63:0] mpc = '0, mpc_now = '0, ptgt = '0;
    logic        err = 1'b0, err_now = 1'b0, pend = 1'b0, phalt = 1'b0;
    int          wcnt = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock of stimulus; the model advances to the state expected after the next edge.
    task automatic drive(input logic r, input logic st, input logic sl, input logic br,
                         input logic [63:0] tgt, input logic h, input logic rdy,
                         input logic [31:0] d);
        @(posedge clk);
        #2;
        reset = r; start = st; stall = sl; branch_taken = br; branch_target = tgt;
        halt = h; mem_ready = rdy; mem_rdata = d;
        ph_now  = ph;
        mpc_now = mpc;
        err_now = err;
        if (r) begin
            ph = P_IDLE; err = 1'b0; mpc = BOOT; pend = 1'b0; phalt = 1'b0; wcnt = 0;
        end else begin
            case (ph)
                P_IDLE: if (st) begin
                    ph = P_WAIT; mpc = BOOT; pend = 1'b0; phalt = 1'b0; wcnt = 0;
                end
                P_WAIT: begin
                    if (h) phalt = 1'b1;
                    else if (br && !phalt) begin
                        if (tgt[1:0] != 2'b00) begin ph = P_ERR; err = 1'b1; end
                        else begin pend = 1'b1; ptgt = tgt; end
                    end
                    if (ph == P_WAIT) begin
                        if (rdy) begin
                            if (phalt) ph = P_HALT;
                            else if (pend) begin mpc = ptgt; pend = 1'b0; wcnt = 0; end
                            else begin
                                pres_q.push_back('{pc: mpc, data: d, cyc: cyc + 1});
                                ph = P_SHOW;
                            end
                        end else begin
                            wcnt++;
`ifdef FETCH_TIMEOUT_EN
                            if (wcnt == TO) begin ph = P_ERR; err = 1'b1; end
`endif
                        end
                    end
                end
                P_SHOW: begin
                    if (h) ph = P_HALT;
                    else if (br) begin
                        if (tgt[1:0] != 2'b00) begin ph = P_ERR; err = 1'b1; end
                        else begin mpc = tgt; ph = P_WAIT; wcnt = 0; end
                    end else if (!sl) begin
                        mpc = mpc + 64'd4; ph = P_WAIT; wcnt = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, rdy, $urandom);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, $urandom_range(0, 1), $urandom);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, $urandom_range(0, 1), $urandom);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, $urandom);
    endtask

    task automatic do_start();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, $urandom);
    endtask

    // Monitor: samples mid-cycle, pops presentations from the scoreboard.
    always @(negedge clk) begin
        if (ph_now != P_UNK) begin
            check("mem_req", {63'b0, mem_req}, {63'b0, ph_now == P_WAIT});
            check("instr_valid", {63'b0, instr_valid}, {63'b0, ph_now == P_SHOW});
            check("busy", {63'b0, busy},
                  {63'b0, (ph_now == P_WAIT) || (ph_now == P_SHOW) || (ph_now == P_ERR)});
            check("fetch_err", {63'b0, fetch_err}, {63'b0, err_now});
            if (ph_now == P_WAIT) check("mem_addr", mem_addr, mpc_now);
            if (ph_now == P_IDLE) begin
                check("idle_mem_addr", mem_addr, 64'h0);
                check("idle_pc_out", pc_out, 64'h0);
                check("idle_instruction", {32'b0, instruction}, {32'b0, NOP});
            end
            if (instr_valid && !prev_valid) begin
                if (pres_q.size() == 0) begin
                    check("unexpected_instr_valid", 64'h1, 64'h0);
                end else begin
                    held = pres_q.pop_front();
                    check("pc_out", pc_out, held.pc);
                    check("instruction", {32'b0, instruction}, {32'b0, held.data});
                    check("present_cycle", 64'(cyc), 64'(held.cyc));
                end
            end else if (instr_valid) begin
                check("stable_pc_out", pc_out, held.pc);
                check("stable_instruction", {32'b0, instruction}, {32'b0, held.data});
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        logic [63:0] t;
        logic        r, st, sl, br, h, rdy;

        // Straight-line fetch: 0, 4, 8 on alternate cycles.
        do_reset();
        do_start();
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h00200113);
            idle(1'b0);
        end
        // Stall for three cycles in VALID.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'hdeadbeef);
        for (int unsigned i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, $urandom);
        idle(1'b0);
        // Branch during FETCH, response two cycles later is discarded.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 1'b0, $urandom);
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h11111111);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h22222222);
        idle(1'b0);
        // Halt during FETCH: request held until the response, then HALTED; start ignored.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        for (int unsigned i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, $urandom);

        // Misaligned branch target from VALID.
        do_reset();
        do_start();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, $urandom);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h102, 1'b0, 1'b0, $urandom);
        for (int unsigned i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h200, 1'b0, 1'b1, $urandom);

        // Memory never answers.
        do_reset();
        do_start();
        for (int unsigned i = 0; i < 30; i++) idle(1'b0);

        // Randomized episodes, including mid-flight resets.
        for (int unsigned ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int unsigned c = 0; c < 120; c++) begin
                t   = {$urandom, $urandom};
                t   = ($urandom_range(0, 99) < 4) ? (t | 64'h2) : (t & ~64'h3);
                r   = $urandom_range(0, 199) == 0;
                st  = $urandom_range(0, 99) < 40;
                sl  = $urandom_range(0, 99) < 35;
                br  = $urandom_range(0, 99) < 12;
                h   = $urandom_range(0, 99) < 2;
                rdy = $urandom_range(0, 99) < 45;
                drive(r, st, sl, br, t, h, rdy, $urandom);
            end
        end
        do_reset();
        idle(1'b0);
        idle(1'b0);

        n_checks++;
        if (pres_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_presentations: got %0d expected 0", pres_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_ctrl.md
INSTRUCTION_FETCH_CTRL -- requirements
Module: instruction_fetch_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter BOOT_ADDR, default 64'h0: PC loaded on start.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: maximum FETCH cycles without mem_ready.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins fetching from BOOT_ADDR.
REQ-007 stall  in  1  downstream cannot accept the presented instruction.
REQ-008 branch_taken  in  1  redirect request.
REQ-009 branch_target  in  64  redirect PC.
REQ-010 halt  in  1  stop fetching.
REQ-011 mem_req  out  1  instruction memory read request.
REQ-012 mem_addr  out  64  read address (current PC).
REQ-013 mem_ready  in  1  read data valid this cycle.
REQ-014 mem_rdata  in  32  read data.
REQ-015 instr_valid  out  1  instruction/pc_out valid.
REQ-016 instruction  out  32  fetched instruction.
REQ-017 pc_out  out  64  PC of presented instruction.
REQ-018 busy  out  1  state is neither IDLE nor HALTED.
REQ-019 fetch_err  out  1  sticky error flag.

Function
REQ-020 States SHALL be IDLE, FETCH, VALID, HALTED, ERROR; IDLE on reset.
REQ-021 IDLE: on start, load pc=BOOT_ADDR, go FETCH; all other inputs ignored.
REQ-022 FETCH: mem_req=1, mem_addr=pc; mem_req SHALL stay high until the cycle mem_ready=1.
REQ-023 FETCH with mem_ready=1: capture mem_rdata into instruction, pc_out=pc, go VALID (response latency 1 cycle).
REQ-024 VALID: instr_valid=1, outputs stable; if stall=0, pc=pc+4 (mod 2^64 wrap) and go FETCH; if stall=1, hold.
REQ-025 Input priority SHALL be reset > halt > branch_taken > stall.
REQ-026 Branch in VALID: drop instruction, pc=branch_target, go FETCH.
REQ-027 Branch in FETCH: latch target as pending; on mem_ready, discard data (no instr_valid), pc=target, go FETCH.
REQ-028 Halt in VALID: go HALTED. Halt in FETCH: deferred until mem_ready; data discarded, then HALTED.
REQ-029 Misaligned target (branch_target[1:0]!=0): go ERROR, set fetch_err; no request issued.
REQ-030 HALTED and ERROR: mem_req=0, instr_valid=0; exit only via reset (start ignored).
REQ-031 Peak throughput SHALL be one instruction per two cycles.

Reset
REQ-032 Reset SHALL force state IDLE, pc=BOOT_ADDR, pending-branch cleared, mem_req=0, mem_addr=0, instr_valid=0, instruction=32'h00000013 (NOP), pc_out=0, busy=0, fetch_err=0.
REQ-033 Reset mid-FETCH SHALL drop mem_req next edge; a late mem_ready SHALL be ignored.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN, when defined: counter counts FETCH cycles, cleared on entry to FETCH; reaching TIMEOUT_CYCLES without mem_ready SHALL go ERROR, set fetch_err, drop mem_req.
REQ-035 Without FETCH_TIMEOUT_EN: no counter, FETCH waits indefinitely; fetch_err only from misalignment.

Structure
REQ-036 Shared package fetch_pkg SHALL hold the state enum, XLEN=64, INSTR_W=32, NOP_INSTR=32'h00000013.
REQ-037 Sub-module fetch_watchdog (counter + compare) SHALL be instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-038 Reset, start, mem_ready 1 cycle after each request, 0x00200113 returned -> instr_valid with pc_out 0, 4, 8 on alternate cycles.
REQ-039 stall=1 for 3 cycles in VALID -> instruction/pc_out unchanged, no mem_req, pc advances only after release.
REQ-040 branch_taken in FETCH, target 0x100, mem_ready 2 cycles later -> data discarded, next mem_addr=0x100.
REQ-041 halt in FETCH before mem_ready -> mem_req held until mem_ready, then HALTED, busy=0, no instr_valid.
REQ-042 branch_target 0x102 -> ERROR, fetch_err=1, mem_req=0 until reset.
REQ-043 FETCH_TIMEOUT_EN, mem_ready never asserted -> fetch_err=1 after 15 FETCH cycles; without macro, mem_req stays high.
